vending_machine_param: RTL and testbench
========================================

Name: vending_machine_param

Overview:
Parametrised, multi-item successor to the fixed-price coke vending FSM. Coins arrive with a valid strobe and are credited in 5 rs units. A vend happens only on an explicit item select. Change and cancel refunds are returned one unit per handshake.
Sits between the coin acceptor front end and the dispenser/refund mechanics.

Parameters:
CREDIT_W, 4, width of the credit register in 5 rs units.
PRICE, 3, item price in units (3 = 15 rs); 1 <= PRICE <= MAX_CREDIT.
MAX_CREDIT, 6, maximum credit held in units; must be < 2**CREDIT_W.
N_ITEMS, 2, number of selectable items.
SEL_W, 1, item select width; 2**SEL_W >= N_ITEMS.
STOCK_W, 4, per-item stock counter width (STOCK_COUNT_EN only).
STOCK_INIT, 8, stock loaded at reset or refill; < 2**STOCK_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
coin_valid  in  1  coin present this cycle
coin  in  2  01=1 unit (5 rs), 10=2 (10 rs), 11=3 (15 rs); 00 with coin_valid is ignored
sel_valid  in  1  vend request
sel  in  SEL_W  requested item
cancel  in  1  refund all credit
change_ready  in  1  refund mechanism accepts one unit
refill  in  1  reload all stock (STOCK_COUNT_EN only, else ignored)
coin_accept  out  1  one-cycle pulse, coin credited
coin_reject  out  1  one-cycle pulse, coin returned
vend  out  1  one-cycle dispense pulse
vend_item  out  SEL_W  item dispensed, valid with vend
change_valid  out  1  one refund unit offered
credit  out  CREDIT_W  current credit in units
busy  out  1  high in VEND or CHANGE
sold_out  out  N_ITEMS  per-item empty flag

Behaviour:
- All outputs are registered. Reset (async assert) forces the state to IDLE and clears credit. All outputs go to 0. Credit held at reset is discarded, not refunded.
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0, collecting.
  - VEND: one cycle.
  - CHANGE: refunding.
- Priority within a cycle in IDLE/CREDIT: cancel > sel_valid > coin_valid. A lower-priority coin in the same cycle gets coin_reject.
- Coin: if credit + units <= MAX_CREDIT, then credit += units and coin_accept pulses at n+1; otherwise coin_reject pulses at n+1 and credit is unchanged. IDLE -> CREDIT on the first accepted coin.
- Coins arriving in VEND or CHANGE are rejected.
- sel_valid is ignored (no pulse, no state change) in any of these cases:
  - credit < PRICE;
  - sel >= N_ITEMS;
  - sold_out[sel] is set.
- A valid sel moves to VEND: vend=1 and vend_item=sel for exactly one cycle, credit -= PRICE. Next state is CHANGE if the remaining credit > 0, else IDLE.
- There is no auto-vend at credit >= PRICE.
- cancel in CREDIT -> CHANGE. cancel in IDLE, VEND or CHANGE is ignored.
- CHANGE: change_valid = 1 while credit > 0. Each cycle with change_valid && change_ready decrements credit by 1. When the last unit is taken: change_valid drops the next cycle, state -> IDLE.
- change_valid never drops without a handshake. Holding change_ready low stalls indefinitely.
- sold_out: all zeros without STOCK_COUNT_EN.

Optional Feature:
STOCK_COUNT_EN
- Defined: per-item stock counter, loaded with STOCK_INIT at reset.
  - Decrements on vend of that item; never wraps below 0.
  - sold_out[i] = (stock[i] == 0).
  - refill reloads all counters. refill coincident with vend wins, so that counter = STOCK_INIT.
- Undefined: no counters, sold_out tied to 0, refill ignored, every valid sel can vend.

Decomposition:
- Package vending_pkg:
  - state enum (IDLE, CREDIT, VEND, CHANGE);
  - coin code constants COIN_5/10/15;
  - function coin_units(code) returning units.
- Sub-module vend_stock_counter (one instance per item, generate loop): count, load, decrement, empty flag.

Test Plan:
- rst pulse; coins 01 then 10; sel=0 -> two coin_accept, credit 1 then 3, vend=1 with vend_item=0 for one cycle, credit 0, IDLE, change_valid never high.
- coins 11, 11 (credit 6), sel=1, change_ready=1 -> vend for item 1, then 3 change handshakes, credit 3->2->1->0, busy low after last.
- coin 10, cancel, change_ready=0 for 4 cycles -> change_valid held high with credit 2; release ready -> 2 beats, then IDLE.
- credit 5, coin 11 -> coin_reject, credit 5. Same-cycle cancel+sel_valid+coin -> refund starts, no vend, coin_reject.
- STOCK_COUNT_EN, STOCK_INIT=1: vend item 0 -> sold_out=01. sel 0 with credit 3 -> no vend. refill -> sold_out=00. sel 0 -> vend.
- Assert rst mid-CHANGE with credit 2 -> same cycle all outputs 0, credit 0. Release -> IDLE, coin accepted normally.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and coin decoding for the parametrised vending machine.
package vending_pkg;

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   localparam logic [1:0] COIN_5  = 2'b01;
   localparam logic [1:0] COIN_10 = 2'b10;
   localparam logic [1:0] COIN_15 = 2'b11;

   function automatic logic [1:0] coin_units(input logic [1:0] code);
      case (code)
         COIN_5:  return 2'd1;
         COIN_10: return 2'd2;
         COIN_15: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_stock_counter.sv
// Per-item stock counter: loads STOCK_INIT at reset/refill, saturating decrement on vend.
module vend_stock_counter #(
   parameter int unsigned STOCK_W    = 4,
   parameter int unsigned STOCK_INIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic empty
);

   logic [STOCK_W-1:0] count;

   // load is checked first so a refill coincident with a vend leaves the full count
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= STOCK_W'(STOCK_INIT);
      else if (load)
         count <= STOCK_W'(STOCK_INIT);
      else if (dec && (count != '0))
         count <= count - STOCK_W'(1);
   end

   assign empty = (count == '0);

endmodule

// File: rtl/vending_machine_param.sv
// Multi-item vending controller: coin credit, explicit select, unit-by-unit refund.
// Optional per-item stock tracking is enabled by defining STOCK_COUNT_EN.
module vending_machine_param
   import vending_pkg::*;
#(
   parameter int unsigned CREDIT_W   = 4,
   parameter int unsigned PRICE      = 3,
   parameter int unsigned MAX_CREDIT = 6,
   parameter int unsigned N_ITEMS    = 2,
   parameter int unsigned SEL_W      = 1,
   parameter int unsigned STOCK_W    = 4,
   parameter int unsigned STOCK_INIT = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [1:0]          coin,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel,
   input  logic                cancel,
   input  logic                change_ready,
   input  logic                refill,
   output logic                coin_accept,
   output logic                coin_reject,
   output logic                vend,
   output logic [SEL_W-1:0]    vend_item,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic [N_ITEMS-1:0]  sold_out
);

   localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [SEL_W:0]      ITEMS_C  = (SEL_W+1)'(N_ITEMS);
   localparam int unsigned         SEL_SPAN = 2**SEL_W;

   state_t              state;
   logic [SEL_SPAN-1:0] sold_pad;
   logic [CREDIT_W:0]   credit_sum;
   logic                coin_present, collecting, cancel_go, sel_go, coin_go, coin_bad;

   // Request arbitration: cancel > sel_valid > coin_valid; an ignored select does not block a coin
   always_comb begin
      sold_pad                = '0;
      sold_pad[N_ITEMS-1:0]   = sold_out;
      coin_present = coin_valid && (coin != 2'b00);
      credit_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_units(coin));
      collecting   = (state == IDLE) || (state == CREDIT);
      cancel_go    = (state == CREDIT) && cancel;
      sel_go       = collecting && !cancel_go && sel_valid && (credit >= PRICE_C)
                     && ({1'b0, sel} < ITEMS_C) && !sold_pad[sel];
      coin_go      = collecting && !cancel_go && !sel_go && coin_present && (credit_sum <= MAX_C);
      coin_bad     = coin_present && !coin_go;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         credit       <= '0;
         coin_accept  <= 1'b0;
         coin_reject  <= 1'b0;
         vend         <= 1'b0;
         vend_item    <= '0;
         change_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         coin_accept <= coin_go;
         coin_reject <= coin_bad;
         vend        <= 1'b0;
         vend_item   <= '0;
         unique case (state)
            IDLE, CREDIT: begin
               if (cancel_go) begin
                  state        <= CHANGE;
                  change_valid <= 1'b1;
                  busy         <= 1'b1;
               end else if (sel_go) begin
                  state     <= VEND;
                  credit    <= credit - PRICE_C;
                  vend      <= 1'b1;
                  vend_item <= sel;
                  busy      <= 1'b1;
               end else if (coin_go) begin
                  state  <= CREDIT;
                  credit <= credit_sum[CREDIT_W-1:0];
               end
            end
            VEND: begin
               if (credit != '0) begin
                  state        <= CHANGE;
                  change_valid <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            CHANGE: begin
               if (change_valid && change_ready) begin
                  credit <= credit - CREDIT_W'(1);
                  if (credit == CREDIT_W'(1)) begin
                     state        <= IDLE;
                     change_valid <= 1'b0;
                     busy         <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef STOCK_COUNT_EN
   for (genvar i = 0; i < N_ITEMS; i++) begin : g_stock
      vend_stock_counter #(
         .STOCK_W    (STOCK_W),
         .STOCK_INIT (STOCK_INIT)
      ) u_stock (
         .clk   (clk),
         .rst   (rst),
         .load  (refill),
         .dec   (sel_go && (sel == SEL_W'(i))),
         .empty (sold_out[i])
      );
   end
`else
   localparam int unsigned unused_stock_cfg = STOCK_W + STOCK_INIT;
   logic unused_refill;
   assign unused_refill = refill;
   assign sold_out      = '0;
`endif

endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench: directed scenarios plus random traffic against a unit-counting reference model.
module tb_vending_machine_param;

   localparam int unsigned CREDIT_W   = 4;
   localparam int unsigned PRICE      = 3;
   localparam int unsigned MAX_CREDIT = 6;
   localparam int unsigned N_ITEMS    = 2;
   localparam int unsigned SEL_W      = 1;
   localparam int unsigned STOCK_W    = 4;
   localparam int unsigned STOCK_INIT = 1;
`ifdef STOCK_COUNT_EN
   localparam bit STOCK_EN = 1'b1;
`else
   localparam bit STOCK_EN = 1'b0;
`endif
   localparam int PH_COLLECT = 0;
   localparam int PH_VEND    = 1;
   localparam int PH_REFUND  = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
   logic                change_ready = 1'b0, refill = 1'b0;
   logic [1:0]          coin = 2'b00;
   logic [SEL_W-1:0]    sel = '0;
   logic                coin_accept, coin_reject, vend, change_valid, busy;
   logic [SEL_W-1:0]    vend_item;
   logic [CREDIT_W-1:0] credit;
   logic [N_ITEMS-1:0]  sold_out;

   vending_machine_param #(
      .CREDIT_W   (CREDIT_W),
      .PRICE      (PRICE),
      .MAX_CREDIT (MAX_CREDIT),
      .N_ITEMS    (N_ITEMS),
      .SEL_W      (SEL_W),
      .STOCK_W    (STOCK_W),
      .STOCK_INIT (STOCK_INIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .coin_valid   (coin_valid),
      .coin         (coin),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .change_ready (change_ready),
      .refill       (refill),
      .coin_accept  (coin_accept),
      .coin_reject  (coin_reject),
      .vend         (vend),
      .vend_item    (vend_item),
      .change_valid (change_valid),
      .credit       (credit),
      .busy         (busy),
      .sold_out     (sold_out)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: credit as a plain integer, a coarse phase, and stock per item
   int m_credit, m_phase;
   int m_stock [N_ITEMS];
   int e_accept, e_reject, e_vend, e_item;

   task automatic model_reset();
      m_credit = 0;
      m_phase  = PH_COLLECT;
      e_accept = 0; e_reject = 0; e_vend = 0; e_item = 0;
      for (int i = 0; i < N_ITEMS; i++) m_stock[i] = STOCK_INIT;
   endtask

   task automatic model_step(input int cv, input int c, input int sv, input int s,
                             input int cn, input int cr, input int rf);
      bit present, did_cancel, did_sel;
      present  = (cv != 0) && (c != 0);
      e_accept = 0; e_reject = 0; e_vend = 0; e_item = 0;
      if (m_phase == PH_COLLECT) begin
         did_cancel = (cn != 0) && (m_credit > 0);
         did_sel    = !did_cancel && (sv != 0) && (m_credit >= PRICE) && (s < N_ITEMS)
                      && (!STOCK_EN || m_stock[s] > 0);
         if (did_cancel) begin
            m_phase = PH_REFUND;
         end else if (did_sel) begin
            m_credit -= PRICE;
            e_vend = 1;
            e_item = s;
            m_phase = PH_VEND;
            if (m_stock[s] > 0) m_stock[s]--;
         end else if (present) begin
            if (m_credit + c <= MAX_CREDIT) begin
               m_credit += c;
               e_accept = 1;
            end else begin
               e_reject = 1;
            end
         end
         if ((did_cancel || did_sel) && present) e_reject = 1;
      end else if (m_phase == PH_VEND) begin
         m_phase = (m_credit > 0) ? PH_REFUND : PH_COLLECT;
         if (present) e_reject = 1;
      end else begin
         if (cr != 0) begin
            m_credit--;
            if (m_credit == 0) m_phase = PH_COLLECT;
         end
         if (present) e_reject = 1;
      end
      if (rf != 0)
         for (int i = 0; i < N_ITEMS; i++) m_stock[i] = STOCK_INIT;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      logic [N_ITEMS-1:0] e_sold;
      for (int i = 0; i < N_ITEMS; i++) e_sold[i] = STOCK_EN && (m_stock[i] == 0);
      chk({tag, ".coin_accept"},  32'(coin_accept),  32'(e_accept));
      chk({tag, ".coin_reject"},  32'(coin_reject),  32'(e_reject));
      chk({tag, ".vend"},         32'(vend),         32'(e_vend));
      chk({tag, ".vend_item"},    32'(vend_item),    32'(e_item));
      chk({tag, ".change_valid"}, 32'(change_valid), 32'(m_phase == PH_REFUND));
      chk({tag, ".credit"},       32'(credit),       32'(m_credit));
      chk({tag, ".busy"},         32'(busy),         32'(m_phase != PH_COLLECT));
      chk({tag, ".sold_out"},     32'(sold_out),     32'(e_sold));
   endtask

   task automatic cyc(input string tag, input int cv, input int c, input int sv, input int s,
                      input int cn, input int cr, input int rf);
      coin_valid   = (cv != 0);
      coin         = 2'(c);
      sel_valid    = (sv != 0);
      sel          = SEL_W'(s);
      cancel       = (cn != 0);
      change_ready = (cr != 0);
      refill       = (rf != 0);
      model_step(cv, c, sv, s, cn, cr, rf);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // 5 rs then 10 rs, select item 0: exact price, no change
      cyc("c5",    1, 1, 0, 0, 0, 0, 0);
      cyc("c10",   1, 2, 0, 0, 0, 0, 0);
      cyc("sel0",  0, 0, 1, 0, 0, 0, 0);
      cyc("post0", 0, 0, 0, 0, 0, 0, 0);
      cyc("idle0", 0, 0, 0, 0, 0, 0, 0);

      // refill, then two 15 rs coins and item 1 with three change beats
      cyc("rf1",   0, 0, 0, 0, 0, 0, 1);
      cyc("c15a",  1, 3, 0, 0, 0, 1, 0);
      cyc("c15b",  1, 3, 0, 0, 0, 1, 0);
      cyc("sel1",  0, 0, 1, 1, 0, 1, 0);
      for (int i = 0; i < 5; i++) cyc("chg1", 0, 0, 0, 0, 0, 1, 0);

      // cancel with refund stalled for four cycles, coin during refund rejected
      cyc("c10b",  1, 2, 0, 0, 0, 0, 0);
      cyc("cancel",0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc("stall", (i == 2) ? 1 : 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("drain", 0, 0, 0, 0, 0, 1, 0);

      // overflow reject at credit 5, ignored 00 code, select below price, triple-request cycle
      cyc("c15c",  1, 3, 0, 0, 0, 0, 0);
      cyc("c10c",  1, 2, 0, 0, 0, 0, 0);
      cyc("ovf",   1, 3, 0, 0, 0, 0, 0);
      cyc("nul",   1, 0, 0, 0, 0, 0, 0);
      cyc("triple",1, 1, 1, 0, 1, 0, 0);
      for (int i = 0; i < 7; i++) cyc("drain2", 0, 0, 0, 0, 0, 1, 0);
      cyc("c5b",   1, 1, 0, 0, 0, 0, 0);
      cyc("lowsel",0, 0, 1, 0, 0, 0, 0);
      cyc("cxl2",  0, 0, 0, 0, 1, 1, 0);
      cyc("drain3",0, 0, 0, 0, 0, 1, 0);

      // stock: vend item 0 to empty, retry, refill, vend again; refill coincident with vend
      cyc("rf2",   0, 0, 0, 0, 0, 0, 1);
      cyc("s_c15", 1, 3, 0, 0, 0, 0, 0);
      cyc("s_sel", 0, 0, 1, 0, 0, 0, 0);
      cyc("s_post",0, 0, 0, 0, 0, 0, 0);
      cyc("s_c15b",1, 3, 0, 0, 0, 0, 0);
      cyc("s_out", 0, 0, 1, 0, 0, 0, 0);
      cyc("s_rf",  0, 0, 0, 0, 0, 0, 1);
      cyc("s_sel2",0, 0, 1, 0, 0, 0, 1);
      cyc("s_post2",0,0, 0, 0, 0, 0, 0);

      // asynchronous reset in the middle of a refund
      cyc("r_c10", 1, 2, 0, 0, 0, 0, 0);
      cyc("r_cxl", 0, 0, 0, 0, 1, 0, 0);
      cyc("r_hold",0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clk);
      #1;
      check_all("rst_held");
      rst = 1'b0;
      cyc("r_coin",1, 1, 0, 0, 0, 0, 0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         cyc("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0) ? 1 : 0, int'($urandom_range(0, N_ITEMS - 1)),
             ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
             ($urandom_range(0, 15) == 0) ? 1 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
